// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM-like downstream port between the fetch (inst)
// and memory-stage (data) requesters. Data has priority; a grant that is not
// accepted is held until accepted. Accepted requests are tracked in an
// in-order FIFO so responses can be routed back, and inst responses can be
// dropped after a flush.
module mem_arbiter #(
  parameter int OUTSTANDING_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  input  logic        ex_en,
  output logic        resp_err
);

  localparam int PTR_W = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING_DEPTH);

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_e;

  lock_e                        lock_q;
  logic [OUTSTANDING_DEPTH-1:0] src_q;    // 1 = data, 0 = inst
  logic [OUTSTANDING_DEPTH-1:0] disc_q;
  logic [OUTSTANDING_DEPTH-1:0] valid_q;
  logic [PTR_W-1:0]             rd_ptr_q;
  logic [PTR_W-1:0]             wr_ptr_q;
  logic [CNT_W-1:0]             count_q;
  logic                         resp_err_q;

  logic gnt_valid;
  logic gnt_data;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_src;
  logic head_disc;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Grant selection: a held lock wins; otherwise data over inst when not full.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = 1'b0;
    unique case (lock_q)
      LK_INST: gnt_valid = 1'b1;
      LK_DATA: begin
        gnt_valid = 1'b1;
        gnt_data  = 1'b1;
      end
      default: begin
        if (!full) begin
          if (data_req) begin
            gnt_valid = 1'b1;
            gnt_data  = 1'b1;
          end else if (inst_req) begin
            gnt_valid = 1'b1;
          end
        end
      end
    endcase
  end

  assign mem_req   = gnt_valid;
  assign mem_wr    = gnt_valid & (gnt_data ? data_wr : inst_wr);
  assign mem_size  = !gnt_valid ? '0 : (gnt_data ? data_size  : inst_size);
  assign mem_addr  = !gnt_valid ? '0 : (gnt_data ? data_addr  : inst_addr);
  assign mem_wstrb = !gnt_valid ? '0 : (gnt_data ? data_wstrb : inst_wstrb);
  assign mem_wdata = !gnt_valid ? '0 : (gnt_data ? data_wdata : inst_wdata);

  assign inst_addr_ok = mem_addr_ok & mem_req & ~gnt_data;
  assign data_addr_ok = mem_addr_ok & mem_req &  gnt_data;

  assign push      = mem_req & mem_addr_ok;
  assign pop       = mem_data_ok & ~empty;
  assign head_src  = src_q[rd_ptr_q];
  assign head_disc = disc_q[rd_ptr_q];

  // A flush in the same cycle as the response also kills the head inst entry.
  assign inst_data_ok = pop & ~head_src & ~head_disc & ~ex_en;
  assign data_data_ok = pop &  head_src;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign resp_err     = resp_err_q;

  // Lock tracking: hold an unaccepted grant on its requester until accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_q <= LK_NONE;
    end else if (mem_req && !mem_addr_ok) begin
      lock_q <= gnt_data ? LK_DATA : LK_INST;
    end else if (push) begin
      lock_q <= LK_NONE;
    end
  end

  // Outstanding FIFO: flush marking first, then pop, then push (push slot
  // never aliases a live entry because pushes only occur when not full).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      src_q    <= '0;
      disc_q   <= '0;
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (ex_en) begin
        disc_q <= disc_q | (valid_q & ~src_q);
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        src_q[wr_ptr_q]   <= gnt_data;
        disc_q[wr_ptr_q]  <= ~gnt_data & ex_en;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error for a response arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_err_q <= 1'b0;
    end else if (mem_data_ok && empty) begin
      resp_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter (OUTSTANDING_DEPTH = 2).
module tb_mem_arbiter;

  localparam logic [31:0] IADDR = 32'h0000_1000;
  localparam logic [31:0] DADDR = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        ex_en;
  logic        resp_err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.OUTSTANDING_DEPTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .ex_en(ex_en), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn, ir, dr, dwr, aok, dok, ex;
    logic [31:0] rdata;
    logic        e_req;
    logic [1:0]  e_sel;   // 0 none, 1 inst, 2 data
    logic        e_iaok, e_daok, e_idok, e_ddok, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic ir, logic dr, logic dwr, logic aok,
                              logic dok, logic ex, logic [31:0] rd, logic e_req,
                              logic [1:0] e_sel, logic e_iaok, logic e_daok,
                              logic e_idok, logic e_ddok, logic e_err);
    vec_t v;
    v.rstn = r; v.ir = ir; v.dr = dr; v.dwr = dwr; v.aok = aok; v.dok = dok;
    v.ex = ex; v.rdata = rd; v.e_req = e_req; v.e_sel = e_sel;
    v.e_iaok = e_iaok; v.e_daok = e_daok; v.e_idok = e_idok; v.e_ddok = e_ddok;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input logic r, input logic ir, input logic dr, input logic dwr,
                       input logic aok, input logic dok, input logic ex,
                       input logic [31:0] rd);
    rstn = r; inst_req = ir; data_req = dr; data_wr = dwr;
    mem_addr_ok = aok; mem_data_ok = dok; ex_en = ex; mem_rdata = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    inst_wr = 1'b0; inst_size = 2'd2; inst_addr = IADDR; inst_wstrb = 4'h0;
    inst_wdata = 32'h0; data_size = 2'd2; data_addr = DADDR; data_wstrb = 4'hF;
    data_wdata = 32'hDEAD_BEEF;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    //             rst ir dr dwr aok dok ex rdata          req sel iaok daok idok ddok err
    // idle after reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0));
    // both request, accepted: data first, then inst; responses in order
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 32'h0,          1, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 32'h0,          1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'hAAAA_0001,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'hAAAA_0002,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0));
    // inst stalled 3 cycles, data rises while locked
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 32'h0,          1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 32'h0,          1, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'hBBBB_0003,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'hBBBB_0004,  0, 0, 0, 0, 0, 1, 0));
    // full FIFO blocks a third request, even in the popping cycle
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 32'h0,          1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 32'h0,          1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0, 32'hCCCC_0005,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 32'h0,          1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'hCCCC_0006,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'hCCCC_0007,  0, 0, 0, 0, 1, 0, 0));
    // two inst reads outstanding, flush, both responses discarded
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 32'h0,          1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 32'h0,          1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h0,          0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'hDDDD_0008,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'hDDDD_0009,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0));
    // response with empty FIFO -> sticky error, cleared by reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'hEEEE_000A,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0));
    // data write outstanding across a flush still completes
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 32'h0,          1, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h0,          0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'hFFFF_000B,  0, 0, 0, 0, 0, 1, 0));
    // flush coinciding with the head inst response
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 32'h0,          1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h1234_000C,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0));
    // flush coinciding with inst acceptance -> pushed discarded
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 32'h0,          1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h1234_000D,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.rstn, v.ir, v.dr, v.dwr, v.aok, v.dok, v.ex, v.rdata);
      #3;
      chk("mem_req",      i, {31'b0, mem_req},      {31'b0, v.e_req});
      chk("inst_addr_ok", i, {31'b0, inst_addr_ok}, {31'b0, v.e_iaok});
      chk("data_addr_ok", i, {31'b0, data_addr_ok}, {31'b0, v.e_daok});
      chk("inst_data_ok", i, {31'b0, inst_data_ok}, {31'b0, v.e_idok});
      chk("data_data_ok", i, {31'b0, data_data_ok}, {31'b0, v.e_ddok});
      chk("resp_err",     i, {31'b0, resp_err},     {31'b0, v.e_err});
      if (v.e_req) begin
        chk("mem_addr", i, mem_addr, (v.e_sel == 2'd2) ? DADDR : IADDR);
        chk("mem_wr",   i, {31'b0, mem_wr},
            {31'b0, (v.e_sel == 2'd2) ? v.dwr : 1'b0});
      end
      if (v.e_ddok) chk("data_rdata", i, data_rdata, v.rdata);
      if (v.e_idok) chk("inst_rdata", i, inst_rdata, v.rdata);
      next_cycle();
    end

    // Reset in the middle of an outstanding transaction drops the entry.
    drive(1'b1, 1, 0, 0, 1, 0, 0, 32'h0);
    #3;
    chk("mid_rst_push", 100, {31'b0, inst_addr_ok}, 32'd1);
    next_cycle();
    drive(1'b0, 0, 0, 0, 0, 0, 0, 32'h0);
    next_cycle();
    drive(1'b1, 0, 0, 0, 0, 1, 0, 32'h5555_0001);
    #3;
    chk("mid_rst_no_idok", 101, {31'b0, inst_data_ok}, 32'd0);
    chk("mid_rst_no_ddok", 102, {31'b0, data_data_ok}, 32'd0);
    next_cycle();
    drive(1'b1, 0, 0, 0, 0, 0, 0, 32'h0);
    #3;
    chk("mid_rst_err", 103, {31'b0, resp_err}, 32'd1);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING_DEPTH, default 2, max accepted-but-unanswered requests (power of 2, >=2).
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on posedge clk.
REQ-003 SHALL have port rstn, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have ports inst_req, inst_wr, inst_size[1:0], inst_addr[31:0], inst_wstrb[3:0], inst_wdata[31:0]: inputs, fetch-side SRAM-like request.
REQ-005 SHALL have ports inst_addr_ok, inst_data_ok (output, 1) and inst_rdata (output, 32): fetch-side responses.
REQ-006 SHALL have ports data_req, data_wr, data_size[1:0], data_addr[31:0], data_wstrb[3:0], data_wdata[31:0]: inputs, memory-stage request.
REQ-007 SHALL have ports data_addr_ok, data_data_ok (output, 1) and data_rdata (output, 32): memory-stage responses.
REQ-008 SHALL have ports mem_req, mem_wr, mem_size[1:0], mem_addr[31:0], mem_wstrb[3:0], mem_wdata[31:0]: outputs, the shared downstream port.
REQ-009 SHALL have ports mem_addr_ok, mem_data_ok (input, 1) and mem_rdata (input, 32): downstream responses, returned in request order.
REQ-010 SHALL have port ex_en, input, 1, exception/flush pulse from writeback.
REQ-011 SHALL have port resp_err, output, 1, sticky: unexpected downstream response seen.

Function
REQ-012 SHALL keep a FIFO of OUTSTANDING_DEPTH entries {src (0=inst, 1=data), discard}, plus an occupancy count.
REQ-013 SHALL grant when unlocked and count<DEPTH: data if data_req, else inst if inst_req, else none.
REQ-014 SHALL drive mem_req=1 only while a grant exists; mem_wr/size/addr/wstrb/wdata SHALL mux combinationally from the granted requester.
REQ-015 SHALL assert the granted requester's addr_ok = mem_addr_ok & mem_req; the other requester's addr_ok SHALL be 0.
REQ-016 SHALL lock the grant (register lock_src) when mem_req=1 and mem_addr_ok=0; while locked, grant SHALL stay with lock_src regardless of priority until mem_addr_ok=1, which SHALL clear the lock on the same edge.
REQ-017 SHALL block new grants when count==DEPTH, even if a pop occurs that cycle; an existing lock SHALL NOT arise in that state.
REQ-018 SHALL push {src, discard} on each mem_req & mem_addr_ok edge; discard=1 iff src=inst and ex_en=1 that cycle.
REQ-019 SHALL pop the head on mem_data_ok when count>0; count SHALL be unchanged on simultaneous push and pop.
REQ-020 SHALL assert data_data_ok=mem_data_ok when head src=data; data_rdata=mem_rdata (writes also get data_data_ok).
REQ-021 SHALL assert inst_data_ok=mem_data_ok when head src=inst and discard=0; it SHALL stay 0 for discarded entries, which are still popped.
REQ-022 SHALL route responses combinationally (zero added latency); grant-to-push latency is that of mem_addr_ok.
REQ-023 SHALL, on ex_en=1, set discard on every valid FIFO entry with src=inst, including the head being popped that cycle (that head's inst_data_ok SHALL be 0).
REQ-024 SHALL NOT affect data entries, the lock, or a pending locked inst request on ex_en; that request completes and is pushed discarded only if ex_en coincides with acceptance.
REQ-025 SHALL set resp_err=1 on mem_data_ok with count==0, ignore that response, and hold resp_err until reset.
REQ-026 SHALL wrap FIFO pointers modulo DEPTH.

Reset
REQ-027 SHALL, on rstn=0 at a clock edge, clear count, pointers, discard bits, lock, and resp_err.
REQ-028 SHALL hold all outputs at 0 while count=0, unlocked, and no request is pending: mem_req, all addr_ok/data_ok, and resp_err.
REQ-029 SHALL take reset asserted mid-transaction to drop all outstanding entries; later mem_data_ok SHALL set resp_err.

Verification
REQ-030 SHALL cover this case: both req=1 and mem_addr_ok=1 in the same cycle -> data granted and pushed; inst granted next cycle; responses R1, R2 -> data_data_ok then inst_data_ok, rdata=R1 then R2.
REQ-031 SHALL cover this case: inst_req with mem_addr_ok=0 for 3 cycles, then data_req rises -> mem_addr stays inst_addr until accepted; data granted the cycle after.
REQ-032 SHALL cover this case: DEPTH=2, two accepted reads, third req -> mem_req=0 until a mem_data_ok pop, then granted the following cycle.
REQ-033 SHALL cover this case: two inst reads outstanding, ex_en pulse, two mem_data_ok -> inst_data_ok never asserts; count returns to 0.
REQ-034 SHALL cover this case: mem_data_ok with empty FIFO -> resp_err=1 and no data_ok; rstn=0 for 1 cycle -> resp_err=0.
REQ-035 SHALL cover this case: ex_en during data write outstanding -> data_data_ok still asserts on its response.
